// File: rtl/operand_fetch_pkg.sv
// Shared CPU package: opcodes, instruction field layout, register index width.
// Used by operand_fetch and the ALU.
package operand_fetch_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 4;

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_SL  = 8'h09;
  localparam logic [7:0] OP_SR  = 8'h0A;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 24;
  localparam int RD_HI   = 23;
  localparam int RD_LO   = 20;
  localparam int RS1_HI  = 19;
  localparam int RS1_LO  = 16;
  localparam int RS2_HI  = 15;
  localparam int RS2_LO  = 12;
  localparam int IMM_SEL = 11;
  localparam int IMM_HI  = 10;
  localparam int IMM_LO  = 0;

  typedef struct packed {
    logic [7:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_imm;
    logic [10:0]      imm;
  } dec_t;

  function automatic dec_t decode(input logic [XLEN-1:0] w);
    dec_t d;
    d.op      = w[OP_HI:OP_LO];
    d.rd      = w[RD_HI:RD_LO];
    d.rs1     = w[RS1_HI:RS1_LO];
    d.rs2     = w[RS2_HI:RS2_LO];
    d.use_imm = w[IMM_SEL];
    d.imm     = w[IMM_HI:IMM_LO];
    return d;
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    logic ok;
    unique case (op)
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SL, OP_SR: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Register array: two async read ports, one sync write port.
// Register 0 always reads as zero and ignores writes.
module regfile_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] raddr1,
  output logic [XLEN-1:0]  rdata1,
  input  logic [REG_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata2,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata
);

  logic [XLEN-1:0] mem [NREGS];

  // clear on reset, otherwise write any register but r0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: decode, scoreboard, register read, one-entry issue slot.
// Define OPF_BYPASS_EN to forward same-cycle writeback data into the fetch.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [REG_W-1:0] rd,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             illegal
);

  dec_t            d;
  logic            legal;
  logic            no_b;
  logic            imm_b;
  logic            uses_rs2;
  logic            hit1;
  logic            hit2;
  logic            hitd;
  logic            hazard;
  logic            xfer;
  logic            load;
  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [NREGS-1:0] busy;

  assign d        = decode(instr);
  assign legal    = is_legal(d.op);
  assign no_b     = (d.op == OP_LD) || (d.op == OP_NOT);
  assign imm_b    = !no_b && d.use_imm;
  assign uses_rs2 = !no_b && !d.use_imm;

  regfile_2r1w #(
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (d.rs1),
    .rdata1 (rf1),
    .raddr2 (d.rs2),
    .rdata2 (rf2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

`ifdef OPF_BYPASS_EN
  assign hit1 = wb_en && (wb_addr == d.rs1) && (d.rs1 != '0);
  assign hit2 = wb_en && (wb_addr == d.rs2) && (d.rs2 != '0);
  assign hitd = wb_en && (wb_addr == d.rd);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign hitd = 1'b0;
`endif

  assign hazard = legal && (
    (busy[d.rs1] && !hit1) ||
    (uses_rs2 && busy[d.rs2] && !hit2) ||
    (busy[d.rd] && !hitd));

  assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
  assign xfer     = in_valid && in_ready;
  assign load     = xfer && legal;

  assign opa = hit1 ? wb_data : rf1;

  // second operand: zero, immediate or rs2
  always_comb begin
    opb = '0;
    unique case (1'b1)
      no_b:    opb = '0;
      imm_b:   opb = {21'b0, d.imm};
      default: opb = hit2 ? wb_data : rf2;
    endcase
  end

  // scoreboard: writeback clears, issue sets (issue wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_en) busy[wb_addr] <= 1'b0;
      if (load && d.rd != '0) busy[d.rd] <= 1'b1;
    end
  end

  // issue slot and illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op        <= '0;
      a         <= '0;
      b         <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= xfer && !legal;
      if (load) begin
        out_valid <= 1'b1;
        op        <= d.op;
        a         <= opa;
        b         <= opb;
        rd        <= d.rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
